dp_onedet_pipe: RTL

//  Parametrised, pipelined successor to the 16-bit ones detector in the VU datapath.
//  - Inputs: LANES lanes of WIDTH bits each, one vector per valid cycle.
//  - Per lane: detects all-ones, all-zeros, any-one or any-zero, with per-lane masking.
//  - Outputs: per-lane results, reduced all/any flags and a count of detecting lanes.
//  - Fixed 2-cycle latency, so it can sit beside the vector register read stage.

---
 rtl/dp_onedet_pipe.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/dp_onedet_pipe.sv
// dp_onedet_pipe: two-stage pipelined per-lane ones/zeros detector.
// Stage 1 reduces each GROUP-bit slice of every lane. Stage 2 combines the
// slices into lane results and produces the masked per-lane, all, any and
// count outputs. Build option: define DP_ONEDET_PIPE_STICKY_EN to add a sticky
// all-detect flag and a saturating all-detect hit counter.
module dp_onedet_pipe #(
    parameter int WIDTH = 16,
    parameter int LANES = 8,
    parameter int GROUP = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [LANES*WIDTH-1:0]     input_data,
    input  logic [1:0]                 mode,
    input  logic [LANES-1:0]           lane_mask,
    output logic                       out_valid,
    output logic [LANES-1:0]           lane_det,
    output logic                       all_det,
    output logic                       any_det,
    output logic [$clog2(LANES+1)-1:0] det_count,
    input  logic                       sticky_clr,
    output logic                       sticky_det,
    output logic [CNT_W-1:0]           hit_count
);

    localparam int NG = WIDTH / GROUP;
    localparam int CW = $clog2(LANES + 1);

    // Mode 00 all-ones and 11 any-zero (= not all-ones) both test for ones, so
    // they reduce groups with AND. Modes 01 all-zeros and 10 any-one
    // (= not all-zeros) test for zeros and reduce groups with NOR.
    logic                   w_use_nor;
    logic [LANES*NG-1:0]    w_part;

    logic                   r_v1;
    logic [LANES*NG-1:0]    r_part;
    logic                   r_invert;
    logic [LANES-1:0]       r_mask;

    logic [LANES-1:0]       w_lane_res;
    logic [LANES-1:0]       w_lane_det;
    logic                   w_all;
    logic                   w_any;
    logic [CW-1:0]          w_count;

    logic                   r_out_valid;
    logic [LANES-1:0]       r_lane_det;
    logic                   r_all_det;
    logic                   r_any_det;
    logic [CW-1:0]          r_det_count;

    assign w_use_nor = mode[1] ^ mode[0];

    // First-level group reduction for every lane.
    always_comb begin
        w_part = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int g = 0; g < NG; g++) begin
                if (w_use_nor) begin
                    w_part[l*NG + g] = ~|input_data[l*WIDTH + g*GROUP +: GROUP];
                end else begin
                    w_part[l*NG + g] = &input_data[l*WIDTH + g*GROUP +: GROUP];
                end
            end
        end
    end

    // Stage 1 register: partials plus the control that travels with them.
    // Only mode[1] is needed downstream; it selects the inverting (any-) modes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1     <= 1'b0;
            r_part   <= '0;
            r_invert <= 1'b0;
            r_mask   <= '0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_part   <= w_part;
                r_invert <= mode[1];
                r_mask   <= lane_mask;
            end
        end
    end

    // Second-level reduction, masking and lane reductions.
    always_comb begin
        w_lane_res = '0;
        w_count    = '0;
        for (int l = 0; l < LANES; l++) begin
            w_lane_res[l] = (&r_part[l*NG +: NG]) ^ r_invert;
        end
        w_lane_det = w_lane_res & r_mask;
        for (int l = 0; l < LANES; l++) begin
            w_count = w_count + CW'(w_lane_det[l]);
        end
        // An empty mask must not read as "every lane detected".
        w_all = (r_mask != '0) && (w_lane_det == r_mask);
        w_any = |w_lane_det;
    end

    // Stage 2 register: results update only on a valid slot and hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_lane_det  <= '0;
            r_all_det   <= 1'b0;
            r_any_det   <= 1'b0;
            r_det_count <= '0;
        end else begin
            r_out_valid <= r_v1;
            if (r_v1) begin
                r_lane_det  <= w_lane_det;
                r_all_det   <= w_all;
                r_any_det   <= w_any;
                r_det_count <= w_count;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign lane_det  = r_lane_det;
    assign all_det   = r_all_det;
    assign any_det   = r_any_det;
    assign det_count = r_det_count;

`ifdef DP_ONEDET_PIPE_STICKY_EN
    logic             w_set;
    logic             r_sticky;
    logic [CNT_W-1:0] r_hit;

    assign w_set = r_out_valid & r_all_det;

    // Sticky flag and saturating counter; a set event in the clearing cycle wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sticky <= 1'b0;
            r_hit    <= '0;
        end else if (sticky_clr) begin
            r_sticky <= w_set;
            r_hit    <= w_set ? CNT_W'(1) : '0;
        end else if (w_set) begin
            r_sticky <= 1'b1;
            if (r_hit != '1) begin
                r_hit <= r_hit + CNT_W'(1);
            end
        end
    end

    assign sticky_det = r_sticky;
    assign hit_count  = r_hit;
`else
    logic w_unused_sticky_clr;

    assign w_unused_sticky_clr = sticky_clr;
    assign sticky_det          = 1'b0;
    assign hit_count           = '0;
`endif

endmodule
